// File: rtl/bp_update_scheduler.sv
// Round-robin collector of resolved-branch updates from two execute ports, buffered in a FIFO
// and drained one per cycle to the predictor. Define BP_UPD_STATS_EN to add accept/flush counters.
module bp_update_scheduler #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [63:0]      req0_pc_i,
    input  logic             req0_taken_i,
    input  logic [63:0]      req0_target_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [63:0]      req1_pc_i,
    input  logic             req1_taken_i,
    input  logic [63:0]      req1_target_i,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic             update_valid_o,
    output logic [63:0]      update_pc_o,
    output logic             update_taken_o,
    output logic [63:0]      update_target_o,
    output logic [CNT_W-1:0] pending_o
`ifdef BP_UPD_STATS_EN
   ,output logic [31:0]      stat_accepted_o,
    output logic [31:0]      stat_flushed_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;

    state_t           state;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             rr_ptr;
    logic             full;
    logic             can_push;
    logic             grant0;
    logic             grant1;
    logic             push;
    logic             pop;
    logic             head_live;

    logic [63:0]      mem_pc     [DEPTH];
    logic             mem_taken  [DEPTH];
    logic [63:0]      mem_target [DEPTH];

    // A full FIFO refuses new requests even when it pops this cycle: no pass-through path.
    assign full     = (count == CNT_W'(DEPTH));
    assign can_push = !full && !flush_i && !rst;
    assign grant0   = can_push && req0_valid_i && (!req1_valid_i || !rr_ptr);
    assign grant1   = can_push && req1_valid_i && (!req0_valid_i ||  rr_ptr);
    assign push     = grant0 || grant1;
    assign pop      = (count != '0) && !hold_i && !flush_i && !rst;

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    assign req0_ready_o    = grant0;
    assign req1_ready_o    = grant1;
    assign update_valid_o  = pop;
    assign head_live       = (count != '0) && !rst;
    assign update_pc_o     = head_live ? mem_pc[head]     : '0;
    assign update_taken_o  = head_live ? mem_taken[head]  : 1'b0;
    assign update_target_o = head_live ? mem_target[head] : '0;
    assign pending_o       = count;

    // NOTE: the entry storage has no reset; head/tail/count alone decide which slots are live,
    // so leaving the data array unreset keeps it a plain RAM without changing behaviour.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail]     <= grant0 ? req0_pc_i     : req1_pc_i;
            mem_taken[tail]  <= grant0 ? req0_taken_i  : req1_taken_i;
            mem_target[tail] <= grant0 ? req0_target_i : req1_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rr_ptr <= 1'b0;
            state  <= IDLE;
        end else if (flush_i) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            state  <= IDLE;
        end else begin
            if (push) begin
                tail   <= tail + PTR_W'(1);
                rr_ptr <= grant0;   // next tie goes to the port that lost this one
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count_next;
            case (state)
                IDLE:    if (push) state <= hold_i ? HOLD : DRAIN;
                DRAIN:   if (hold_i) state <= HOLD;
                         else if (count_next == '0) state <= IDLE;
                HOLD:    if (!hold_i) state <= (count_next != '0) ? DRAIN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BP_UPD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_accepted_o <= '0;
            stat_flushed_o  <= '0;
        end else begin
            if (push) begin
                stat_accepted_o <= stat_accepted_o + 32'd1;
            end
            if (flush_i) begin
                stat_flushed_o <= stat_flushed_o + 32'(count);
            end
        end
    end
`else
    // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Randomized bench for bp_update_scheduler: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bp_update_scheduler;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid_i, req0_ready_o, req0_taken_i;
    logic [63:0]      req0_pc_i, req0_target_i;
    logic             req1_valid_i, req1_ready_o, req1_taken_i;
    logic [63:0]      req1_pc_i, req1_target_i;
    logic             hold_i, flush_i;
    logic             update_valid_o, update_taken_o;
    logic [63:0]      update_pc_o, update_target_o;
    logic [CNT_W-1:0] pending_o;
`ifdef BP_UPD_STATS_EN
    logic [31:0]      stat_accepted_o, stat_flushed_o;
`endif

    bp_update_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_pc_i(req0_pc_i),
        .req0_taken_i(req0_taken_i), .req0_target_i(req0_target_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_pc_i(req1_pc_i),
        .req1_taken_i(req1_taken_i), .req1_target_i(req1_target_i),
        .hold_i(hold_i), .flush_i(flush_i),
        .update_valid_o(update_valid_o), .update_pc_o(update_pc_o),
        .update_taken_o(update_taken_o), .update_target_o(update_target_o),
        .pending_o(pending_o)
`ifdef BP_UPD_STATS_EN
       ,.stat_accepted_o(stat_accepted_o), .stat_flushed_o(stat_flushed_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue of entries, the tie pointer an integer.
    ent_t        q[$];
    int          rr = 0;
    int          n;
    bit          m_full, m_can, m_g0, m_g1, m_valid;
    ent_t        m_head, new_ent;
    logic [31:0] m_acc = 0, m_fl = 0;

    always @(negedge clk) begin
        n       = q.size();
        m_full  = (n == DEPTH);
        m_can   = !m_full && !flush_i && !rst;
        m_g0    = m_can && req0_valid_i && (!req1_valid_i || rr == 0);
        m_g1    = m_can && req1_valid_i && (!req0_valid_i || rr == 1);
        m_valid = (n != 0) && !hold_i && !flush_i && !rst;
        if (n != 0 && !rst) m_head = q[0];
        else m_head = '{pc: 64'd0, taken: 1'b0, target: 64'd0};
        if (chk_en) begin
            check("req0_ready", {63'd0, req0_ready_o}, {63'd0, m_g0});
            check("req1_ready", {63'd0, req1_ready_o}, {63'd0, m_g1});
            check("update_valid", {63'd0, update_valid_o}, {63'd0, m_valid});
            check("update_pc", update_pc_o, m_head.pc);
            check("update_taken", {63'd0, update_taken_o}, {63'd0, m_head.taken});
            check("update_target", update_target_o, m_head.target);
            if (!rst) check("pending", 64'(pending_o), 64'(n));
`ifdef BP_UPD_STATS_EN
            check("stat_accepted", 64'(stat_accepted_o), 64'(m_acc));
            check("stat_flushed", 64'(stat_flushed_o), 64'(m_fl));
`endif
        end
        if (rst) begin
            q.delete();
            rr = 0; m_acc = 0; m_fl = 0;
        end else if (flush_i) begin
            m_fl = m_fl + 32'(n);
            q.delete();
        end else begin
            if (m_valid) void'(q.pop_front());
            if (m_g0 || m_g1) begin
                new_ent.pc     = m_g0 ? req0_pc_i     : req1_pc_i;
                new_ent.taken  = m_g0 ? req0_taken_i  : req1_taken_i;
                new_ent.target = m_g0 ? req0_target_i : req1_target_i;
                q.push_back(new_ent);
                rr = m_g0 ? 1 : 0;
                m_acc++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    task automatic idle_inputs();
        req0_valid_i = 0; req1_valid_i = 0; hold_i = 0; flush_i = 0;
        req0_pc_i = 0; req0_taken_i = 0; req0_target_i = 0;
        req1_pc_i = 0; req1_taken_i = 0; req1_target_i = 0;
    endtask

    logic [63:0] exp_pc [4];

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;

        // Single request on port 0, one-cycle latency to the predictor.
        req0_valid_i = 1; req0_pc_i = 64'h1000; req0_taken_i = 1; req0_target_i = 64'h2000;
        look();
        check("t1_ready0", {63'd0, req0_ready_o}, 64'd1);
        check("t1_pend0", 64'(pending_o), 64'd0);
        step();
        req0_valid_i = 0;
        look();
        check("t1_valid", {63'd0, update_valid_o}, 64'd1);
        check("t1_pc", update_pc_o, 64'h1000);
        check("t1_taken", {63'd0, update_taken_o}, 64'd1);
        check("t1_target", update_target_o, 64'h2000);
        check("t1_pend1", 64'(pending_o), 64'd1);
        step();
        look();
        check("t1_pend_after", 64'(pending_o), 64'd0);
        check("t1_valid_after", {63'd0, update_valid_o}, 64'd0);

        // Reset returns the tie pointer to port 0.
        step(); rst = 1; step(); rst = 0;

        // Alternating grants under hold, then in-order drain.
        hold_i = 1;
        exp_pc = '{64'hA000, 64'hB001, 64'hA002, 64'hB003};
        for (int i = 0; i < 4; i++) begin
            req0_valid_i = 1; req1_valid_i = 1;
            req0_pc_i = 64'hA000 + 64'(i); req1_pc_i = 64'hB000 + 64'(i);
            look();
            check("t2_ready0", {63'd0, req0_ready_o}, 64'((i % 2) == 0));
            check("t2_ready1", {63'd0, req1_ready_o}, 64'((i % 2) == 1));
            step();
        end
        req0_valid_i = 0; req1_valid_i = 0; hold_i = 0;
        for (int i = 0; i < 4; i++) begin
            look();
            check("t2_drain_pc", update_pc_o, exp_pc[i]);
            check("t2_drain_pend", 64'(pending_o), 64'(4 - i));
            step();
        end
        look();
        check("t2_empty", 64'(pending_o), 64'd0);

        // Fill to DEPTH under hold; release and see a push accepted again.
        step();
        hold_i = 1; req0_valid_i = 1; req1_valid_i = 1;
        for (int i = 0; i < DEPTH; i++) begin
            req0_pc_i = 64'hC000 + 64'(i); req1_pc_i = 64'hD000 + 64'(i);
            step();
        end
        look();
        check("t3_full_r0", {63'd0, req0_ready_o}, 64'd0);
        check("t3_full_r1", {63'd0, req1_ready_o}, 64'd0);
        check("t3_full_pend", 64'(pending_o), 64'(DEPTH));
        step();
        hold_i = 0;
        look();
        check("t3_pop_valid", {63'd0, update_valid_o}, 64'd1);
        check("t3_nopass", {63'd0, req0_ready_o | req1_ready_o}, 64'd0);
        step();
        look();
        check("t3_pend7", 64'(pending_o), 64'(DEPTH - 1));
        check("t3_reaccept", {63'd0, req0_ready_o | req1_ready_o}, 64'd1);
        step();
        req0_valid_i = 0; req1_valid_i = 0;
        repeat (DEPTH + 1) step();

        // Flush with five queued and port 0 still requesting.
        hold_i = 1; req0_valid_i = 1;
        for (int i = 0; i < 5; i++) begin
            req0_pc_i = 64'hE000 + 64'(i);
            step();
        end
        hold_i = 0; flush_i = 1;
        look();
        check("t4_ready0", {63'd0, req0_ready_o}, 64'd0);
        check("t4_valid", {63'd0, update_valid_o}, 64'd0);
        check("t4_pend5", 64'(pending_o), 64'd5);
        step();
        flush_i = 0; req0_valid_i = 0;
        look();
        check("t4_pend0", 64'(pending_o), 64'd0);
`ifdef BP_UPD_STATS_EN
        check("t4_stat_flushed", 64'(stat_flushed_o), 64'd5);
`endif
        step();

        // Steady push/pop through pointer wrap-around.
        req0_valid_i = 1;
        for (int i = 0; i < 20; i++) begin
            req0_pc_i = 64'h100 + 64'(4 * i);
            if (i > 0) begin
                look();
                check("t5_pend", 64'(pending_o), 64'd1);
                check("t5_pc", update_pc_o, 64'h100 + 64'(4 * (i - 1)));
            end
            step();
        end
        req0_valid_i = 0;
        look();
        check("t5_last_pc", update_pc_o, 64'h100 + 64'(4 * 19));
        step();
        look();
        check("t5_empty", 64'(pending_o), 64'd0);
        step();

        // Reset with three entries queued.
        hold_i = 1; req0_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            req0_pc_i = 64'hF000 + 64'(i);
            step();
        end
        req0_valid_i = 0; rst = 1;
        look();
        check("t6_rst_valid", {63'd0, update_valid_o}, 64'd0);
        step();
        rst = 0; hold_i = 0; req0_valid_i = 1; req1_valid_i = 1;
        look();
        check("t6_pend", 64'(pending_o), 64'd0);
        check("t6_valid", {63'd0, update_valid_o}, 64'd0);
        check("t6_tie_r0", {63'd0, req0_ready_o}, 64'd1);
        check("t6_tie_r1", {63'd0, req1_ready_o}, 64'd0);
        step();
        idle_inputs();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req0_valid_i  = ($urandom_range(99) < 60);
            req1_valid_i  = ($urandom_range(99) < 60);
            req0_pc_i     = {$urandom, $urandom};
            req1_pc_i     = {$urandom, $urandom};
            req0_target_i = {$urandom, $urandom};
            req1_target_i = {$urandom, $urandom};
            req0_taken_i  = $urandom_range(1);
            req1_taken_i  = $urandom_range(1);
            hold_i        = ($urandom_range(99) < 25);
            flush_i       = ($urandom_range(99) < 3);
            rst           = ($urandom_range(199) == 0);
            step();
        end
        idle_inputs();
        rst = 0;
        repeat (DEPTH + 2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
